// File: rtl/div_iterative_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle at issue.
module div_iterative_unit #(
    parameter int XLEN = 32,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [2:0]      issue_fn3,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [XLEN-1:0] issue_rs2,
    input  logic [ID_W-1:0] issue_id,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ack,
    output logic [XLEN-1:0] result_data,
    output logic [ID_W-1:0] result_id
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;     // dividend bits shift out MSB-first, quotient bits shift in
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            want_rem_q, want_rem_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [ID_W-1:0] id_q, id_d;

    logic            is_signed, is_div_op, div_zero, sgn_ovf;
    logic [XLEN-1:0] abs_rs1, abs_rs2;
    logic [XLEN:0]   rem_shift, rem_diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_next, quo_next, rem_fin, quo_fin;

    assign is_signed = ~issue_fn3[0];
    assign is_div_op = issue_fn3[2];
    assign div_zero  = (issue_rs2 == '0);
    assign sgn_ovf   = is_signed && (issue_rs1 == MOST_NEG) && (issue_rs2 == '1);
    assign abs_rs1   = (is_signed && issue_rs1[XLEN-1]) ? -issue_rs1 : issue_rs1;
    assign abs_rs2   = (is_signed && issue_rs2[XLEN-1]) ? -issue_rs2 : issue_rs2;

    // Partial remainder stays below the divisor, so one extra bit is enough to see the borrow.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign q_bit     = ~rem_diff[XLEN];
    assign rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_next  = {quo_q[XLEN-2:0], q_bit};
    assign quo_fin   = q_neg_q ? -quo_next : quo_next;
    assign rem_fin   = r_neg_q ? -rem_next : rem_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        want_rem_d = want_rem_q;
        data_d     = data_q;
        id_d       = id_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_valid) begin
                        id_d       = issue_id;
                        want_rem_d = issue_fn3[1];
                        q_neg_d    = is_signed && (issue_rs1[XLEN-1] ^ issue_rs2[XLEN-1]) && !div_zero;
                        r_neg_d    = is_signed && issue_rs1[XLEN-1];
                        quo_d      = abs_rs1;
                        dvs_d      = abs_rs2;
                        rem_d      = '0;
                        cnt_d      = '0;
                        // MUL encodings never take the shortcut so they always iterate the full length.
                        if (is_div_op && div_zero) begin
                            data_d  = issue_fn3[1] ? issue_rs1 : '1;
                            state_d = DONE;
                        end else if (is_div_op && sgn_ovf) begin
                            data_d  = issue_fn3[1] ? '0 : MOST_NEG;
                            state_d = DONE;
                        end else begin
                            state_d = DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        data_d  = want_rem_q ? rem_fin : quo_fin;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            want_rem_q <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            want_rem_q <= want_rem_d;
            data_q     <= data_d;
            id_q       <= id_d;
        end
    end

    assign issue_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign result_data  = data_q;
    assign result_id    = id_q;
endmodule

// File: tb/tb_div_iterative_unit.sv
// Self-checking bench for div_iterative_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written flush/reset/back-pressure sequences.
module tb_div_iterative_unit;
    localparam logic [2:0] DIV_F  = 3'b100;
    localparam logic [2:0] DIVU_F = 3'b101;
    localparam logic [2:0] REM_F  = 3'b110;
    localparam logic [2:0] REMU_F = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [2:0]  issue_fn3 = '0;
    logic [31:0] issue_rs1 = '0;
    logic [31:0] issue_rs2 = '0;
    logic [2:0]  issue_id = '0;
    logic        flush = 1'b0;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic [31:0] result_data;
    logic [2:0]  result_id;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    div_iterative_unit #(.XLEN(32), .ID_W(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fn3(issue_fn3), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_id(issue_id),
        .flush(flush),
        .result_valid(result_valid), .result_ack(result_ack),
        .result_data(result_data), .result_id(result_id)
    );

    typedef struct {
        logic [2:0]  fn3;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  id;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics straight from the ISA rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic rem;
        sgn = ~f[0];
        rem = f[1];
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
            if (rem) return 32'($signed(a) % $signed(b));
            return 32'($signed(a) / $signed(b));
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [2:0] id);
        @(negedge clk);
        chk("ready_before_issue", {31'd0, issue_ready}, 32'd1);
        issue_fn3   = f;
        issue_rs1   = a;
        issue_rs2   = b;
        issue_id    = id;
        issue_valid = 1'b1;
        @(posedge clk);
        #1 issue_valid = 1'b0;
    endtask

    // lat = number of clock edges after acceptance until the edge where valid is first seen high.
    task automatic collect(input int hold, output logic [31:0] d, output logic [2:0] i, output int lat);
        lat = 0;
        d = '0;
        i = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            lat++;
            if (result_valid) break;
        end
        if (!result_valid) begin
            tests++;
            failed++;
            $display("FAIL result_timeout: got no result_valid, expected one within 200 cycles");
            lat = -1;
            return;
        end
        d = result_data;
        i = result_id;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
            chk("hold_data", result_data, d);
            chk("hold_id", {29'd0, result_id}, {29'd0, i});
            chk("hold_not_ready", {31'd0, issue_ready}, 32'd0);
        end
        result_ack = 1'b1;
        @(posedge clk);
        #1 result_ack = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] id, input logic [31:0] exp, input int exp_lat, input int hold);
        logic [31:0] d;
        logic [2:0]  i;
        int          lat;
        issue(f, a, b, id);
        collect(hold, d, i, lat);
        $display("[TB] fn3=%b rs1=0x%08h rs2=0x%08h id=%0d -> data=0x%08h id=%0d lat=%0d (exp 0x%08h lat %0d)",
                 f, a, b, id, d, i, lat, exp, exp_lat);
        chk("result_data", d, exp);
        chk("result_id", {29'd0, i}, {29'd0, id});
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        vec_t vecs[9];
        logic [2:0]  f;
        logic [31:0] a, b;
        logic        saw_valid;

        vecs[0] = '{DIVU_F, 32'd100,        32'd7,          3'd5, 32'd14,         33};
        vecs[1] = '{REMU_F, 32'd100,        32'd7,          3'd5, 32'd2,          33};
        vecs[2] = '{DIV_F,  32'hFFFF_FFEC,  32'd3,          3'd1, 32'hFFFF_FFFA,  33};
        vecs[3] = '{REM_F,  32'hFFFF_FFEC,  32'd3,          3'd2, 32'hFFFF_FFFE,  33};
        vecs[4] = '{REM_F,  32'd20,         32'hFFFF_FFFD,  3'd3, 32'd2,          33};
        vecs[5] = '{DIVU_F, 32'h1234,       32'd0,          3'd4, 32'hFFFF_FFFF,  1};
        vecs[6] = '{REM_F,  32'h1234,       32'd0,          3'd6, 32'h1234,       1};
        vecs[7] = '{DIV_F,  32'h8000_0000,  32'hFFFF_FFFF,  3'd7, 32'h8000_0000,  1};
        vecs[8] = '{REM_F,  32'h8000_0000,  32'hFFFF_FFFF,  3'd0, 32'd0,          1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, issue_ready}, 32'd1);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_data", result_data, 32'd0);
        chk("reset_id", {29'd0, result_id}, 32'd0);

        foreach (vecs[n])
            run_op(vecs[n].fn3, vecs[n].a, vecs[n].b, vecs[n].id, vecs[n].exp, vecs[n].lat, 0);

        // Back-pressure: hold ack off for 5 cycles, then issue on the very next cycle.
        run_op(DIVU_F, 32'd100, 32'd7, 3'd5, 32'd14, 33, 5);
        run_op(DIVU_F, 32'd1000, 32'd10, 3'd2, 32'd100, 33, 0);

        for (int r = 0; r < 40; r++) begin
            f = 3'b100 | 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(f, a, b, 3'(r), model(f, a, b), model_lat(f, a, b), 0);
        end

        // Flush mid-divide: no result ever appears, unit returns to idle.
        issue(DIVU_F, 32'hFFFF_FFFF, 32'd3, 3'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_ready", {31'd0, issue_ready}, 32'd1);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_valid |= result_valid;
        end
        chk("flush_no_result", {31'd0, saw_valid}, 32'd0);
        run_op(DIVU_F, 32'd9, 32'd2, 3'd1, 32'd4, 33, 0);

        // Flush together with issue_valid: the op must not be taken.
        @(negedge clk);
        issue_fn3 = DIVU_F; issue_rs1 = 32'd50; issue_rs2 = 32'd0; issue_id = 3'd6;
        issue_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 begin issue_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("flush_issue_valid", {31'd0, result_valid}, 32'd0);

        // Async reset mid-divide.
        issue(DIV_F, 32'hFFFF_FF00, 32'd7, 3'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mid_data", result_data, 32'd0);
        chk("rst_mid_id", {29'd0, result_id}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, issue_ready}, 32'd1);
        run_op(REM_F, 32'hFFFF_FF00, 32'd7, 3'd4, model(REM_F, 32'hFFFF_FF00, 32'd7), 33, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
